// File: rtl/rat_path_player.sv
// Replays moves popped from the rat solver's move stack and streams each visited (X,Y) cell.
// Define RAT_PATH_REVISIT_CHECK_EN to also abort on revisits via a 256-cell visited bitmap.
module rat_path_player #(
    parameter logic [3:0] START_X   = 4'd0,
    parameter logic [3:0] START_Y   = 4'd0,
    parameter logic [3:0] GOAL_X    = 4'd15,
    parameter logic [3:0] GOAL_Y    = 4'd15,
    parameter int         MAX_STEPS = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       empty,
    input  logic [1:0] move,
    output logic       pop,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic [7:0] steps,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EMIT  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

    logic [2:0] state;
    logic [3:0] next_x;
    logic [3:0] next_y;
    logic       off_grid;
    logic       at_limit;
    logic       revisit;
    logic       take_step;
    logic       can_start;

    // Neighbour and bounds are evaluated before any update, so X/Y can never wrap.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        next_x   = X;
        next_y   = Y;
        off_grid = 1'b0;
        case (move)
            2'b00: begin off_grid = (X == 4'd0);  next_x = X - 4'd1; end
            2'b01: begin off_grid = (Y == 4'd15); next_y = Y + 4'd1; end
            2'b10: begin off_grid = (Y == 4'd0);  next_y = Y - 4'd1; end
            default: begin off_grid = (X == 4'd15); next_x = X + 4'd1; end
        endcase
    end

    assign at_limit  = (steps == STEP_LIMIT);
    assign can_start = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign take_step = (state == S_FETCH) && !empty && !off_grid && !at_limit && !revisit;

    assign pop       = take_step && !rst;
    assign out_valid = (state == S_EMIT);
    assign busy      = (state == S_EMIT) || (state == S_FETCH);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);

`ifdef RAT_PATH_REVISIT_CHECK_EN
    logic [255:0] visited;

    assign revisit = visited[{next_y, next_x}];

    // NOTE: the bitmap must start clean for every replay, so it is cleared on rst as well as on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            visited <= '0;
        end else if (can_start) begin
            visited                     <= '0;
            visited[{START_Y, START_X}] <= 1'b1;
        end else if (take_step) begin
            visited[{next_y, next_x}] <= 1'b1;
        end
    end
`else
    assign revisit = 1'b0;
`endif

    // NOTE: all state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            X        <= START_X;
            Y        <= START_Y;
            steps    <= 8'd0;
            err_code <= 2'b00;
        end else begin
            case (state)
                S_EMIT: begin
                    if (out_ready)
                        state <= (X == GOAL_X && Y == GOAL_Y) ? S_DONE : S_FETCH;
                end
                S_FETCH: begin
                    if (empty) begin
                        err_code <= 2'b10;
                        state    <= S_ERR;
                    end else if (off_grid) begin
                        err_code <= 2'b01;
                        state    <= S_ERR;
                    end else if (at_limit || revisit) begin
                        err_code <= 2'b11;
                        state    <= S_ERR;
                    end else begin
                        X     <= next_x;
                        Y     <= next_y;
                        steps <= steps + 8'd1;
                        state <= S_EMIT;
                    end
                end
                default: begin
                    // IDLE, DONE and ERR all re-arm the same way.
                    if (can_start) begin
                        X        <= START_X;
                        Y        <= START_Y;
                        steps    <= 8'd0;
                        err_code <= 2'b00;
                        state    <= S_EMIT;
                    end
                end
            endcase
        end
    end

endmodule
